// File: rtl/Load_store_pkg.sv
// rtl/Load_store_pkg.sv - control word handed from issue to the load/store unit
package Load_store_pkg;
  typedef struct packed {
    logic               en;
    logic               we;
    Pu_types::Load_mode mode;
    logic               return_dout;
    logic               return_addr;
    logic               return_addr_early;
    logic               exts;
  } Ctrl;
endpackage

// File: rtl/Pu_types.sv
// rtl/Pu_types.sv - shared processing-unit types: load/store access width
package Pu_types;
  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } Load_mode;
endpackage

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - big-endian data-memory load/store execution stage
// Optional misaligned-access trap: define LOAD_STORE_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  input  Load_store_pkg::Ctrl ctrl,
  input  logic [DATA_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                ready,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [DATA_W-1:0]   dmem_addr,
  output logic [3:0]          dmem_be,
  output logic [DATA_W-1:0]   dmem_wdata,
  input  logic                dmem_ack,
  input  logic                dmem_rvalid,
  input  logic [DATA_W-1:0]   dmem_rdata,
  output logic                res_valid,
  output logic [DATA_W-1:0]   res_data,
  output logic                early_valid,
  output logic [DATA_W-1:0]   early_addr,
  output logic                bus_err,
  output logic                misalign
);
  import Pu_types::*;

  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RDWAIT, S_DONE, S_TRAP} state_t;
  state_t state_q, state_d;

  logic              we_q, ret_dout_q, ret_addr_q, exts_q;
  Load_mode          mode_q;
  logic [DATA_W-1:0] addr_q, dmem_addr_q, dmem_wdata_q, res_data_q, early_addr_q;
  logic [3:0]        dmem_be_q;
  logic [WAIT_W-1:0] wait_q;
  logic              bus_err_q, early_valid_q;

  logic              accept, misaligned, timeout, timeout_fire;
  logic [3:0]        be_d;
  logic [DATA_W-1:0] lane_wdata, load_ext, res_d;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;

  assign accept = issue_valid && ready && ctrl.en;

`ifdef LOAD_STORE_MISALIGN_TRAP_EN
  assign misaligned = (ctrl.mode == HALF && addr[0]) || (ctrl.mode == WORD && addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Ack/rvalid arriving in the last allowed cycle wins over the timeout.
  assign timeout      = (MAX_WAIT != 0) && (wait_q == WAIT_LAST);
  assign timeout_fire = timeout && ((state_q == S_REQ && !dmem_ack) ||
                                    (state_q == S_RDWAIT && !dmem_rvalid));

  always_comb begin
    be_d       = 4'b1111;
    lane_wdata = wdata;
    case (ctrl.mode)
      BYTE: begin
        be_d       = 4'b1000 >> addr[1:0];
        lane_wdata = {24'b0, wdata[7:0]} << {~addr[1:0], 3'b000};
      end
      HALF: begin
        be_d       = addr[1] ? 4'b0011 : 4'b1100;
        lane_wdata = addr[1] ? {16'b0, wdata[15:0]} : {wdata[15:0], 16'b0};
      end
      default: ;
    endcase
  end

  assign rd_byte = 8'(dmem_rdata >> {~addr_q[1:0], 3'b000});
  assign rd_half = addr_q[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];

  always_comb begin
    load_ext = dmem_rdata;
    case (mode_q)
      BYTE:    load_ext = {{24{exts_q & rd_byte[7]}}, rd_byte};
      HALF:    load_ext = {{16{exts_q & rd_half[15]}}, rd_half};
      default: ;
    endcase
    if (we_q) res_d = ret_addr_q ? addr_q : '0;
    else      res_d = ret_dout_q ? load_ext : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      we_q          <= 1'b0;
      ret_dout_q    <= 1'b0;
      ret_addr_q    <= 1'b0;
      exts_q        <= 1'b0;
      mode_q        <= BYTE;
      addr_q        <= '0;
      dmem_addr_q   <= '0;
      dmem_be_q     <= '0;
      dmem_wdata_q  <= '0;
      res_data_q    <= '0;
      early_addr_q  <= '0;
      early_valid_q <= 1'b0;
      bus_err_q     <= 1'b0;
      wait_q        <= '0;
    end else begin
      state_q       <= state_d;
      bus_err_q     <= timeout_fire;
      early_valid_q <= accept && ctrl.return_addr_early;
      if (accept && ctrl.return_addr_early) early_addr_q <= addr;
      if (accept) begin
        we_q         <= ctrl.we;
        mode_q       <= ctrl.mode;
        ret_dout_q   <= ctrl.return_dout;
        ret_addr_q   <= ctrl.return_addr;
        exts_q       <= ctrl.exts;
        addr_q       <= addr;
        dmem_addr_q  <= {addr[DATA_W-1:2], 2'b00};
        dmem_be_q    <= be_d;
        dmem_wdata_q <= lane_wdata;
      end
      if (state_d == S_DONE) res_data_q <= res_d;
      if (state_d == state_q && (state_q == S_REQ || state_q == S_RDWAIT)) wait_q <= wait_q + 1'b1;
      else wait_q <= '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_TRAP: begin
        if (accept) state_d = misaligned ? S_TRAP : S_REQ;
        else        state_d = S_IDLE;
      end
      S_REQ: begin
        if (dmem_ack)     state_d = (we_q || dmem_rvalid) ? S_DONE : S_RDWAIT;
        else if (timeout) state_d = S_IDLE;
      end
      S_RDWAIT: begin
        if (dmem_rvalid)  state_d = S_DONE;
        else if (timeout) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready     = (state_q == S_IDLE) || (state_q == S_DONE);
    dmem_req  = (state_q == S_REQ);
    dmem_we   = (state_q == S_REQ) && we_q;
    res_valid = (state_q == S_DONE);
`ifdef LOAD_STORE_MISALIGN_TRAP_EN
    misalign  = (state_q == S_TRAP);
`else
    misalign  = 1'b0;
`endif
  end

  assign dmem_addr   = dmem_addr_q;
  assign dmem_be     = dmem_be_q;
  assign dmem_wdata  = dmem_wdata_q;
  assign res_data    = res_data_q;
  assign early_valid = early_valid_q;
  assign early_addr  = early_addr_q;
  assign bus_err     = bus_err_q;
endmodule
